// File: rtl/psk_modulator.sv
// Streaming BPSK / Gray-coded QPSK modulator.
// Data words arrive over a valid/ready handshake and are serialised MSB-first.
// Each symbol is one full carrier period read from a signed sine table, with
// the symbol's phase offset added to the table address.
module psk_modulator #(
    parameter int SINE_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int PHASE_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         en,
    input  logic                         mode,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic signed [SINE_WIDTH-1:0] signal_out,
    output logic                         out_valid,
    output logic                         sym_start,
    output logic                         busy
);

    localparam int  N   = 1 << PHASE_WIDTH;
    localparam int  BW  = $clog2(DATA_WIDTH + 1);
    localparam int  AMP = (1 << (SINE_WIDTH - 1)) - 1;
    localparam real PI  = 3.14159265358979323846;

    localparam logic [PHASE_WIDTH-1:0] OFF_HALF  = PHASE_WIDTH'(N / 2);
    localparam logic [PHASE_WIDTH-1:0] OFF_1_8   = PHASE_WIDTH'(N / 8);
    localparam logic [PHASE_WIDTH-1:0] OFF_3_8   = PHASE_WIDTH'((3 * N) / 8);
    localparam logic [PHASE_WIDTH-1:0] OFF_5_8   = PHASE_WIDTH'((5 * N) / 8);
    localparam logic [PHASE_WIDTH-1:0] OFF_7_8   = PHASE_WIDTH'((7 * N) / 8);
    localparam logic [PHASE_WIDTH-1:0] PHASE_MAX = PHASE_WIDTH'(N - 1);

    typedef enum logic {IDLE, RUN} stateT;

    // Rounded-half-away-from-zero sine value; evaluated only at elaboration.
    function automatic int lutValue(input int idx);
        real v;
        v = real'(AMP) * $sin(2.0 * PI * real'(idx) / real'(N));
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return $rtoi(v - 0.5);
    endfunction

    logic signed [SINE_WIDTH-1:0] sineLut [N];

    for (genvar a = 0; a < N; a++) begin : g_lut
        assign sineLut[a] = SINE_WIDTH'(lutValue(a));
    end

    stateT                        state_q;
    logic [PHASE_WIDTH-1:0]       phaseCnt_q;
    logic [DATA_WIDTH-1:0]        shift_q;
    logic [BW-1:0]                bitsLeft_q;
    logic                         qpsk_q;
    logic signed [SINE_WIDTH-1:0] signalOut_q;
    logic                         outValid_q;
    logic                         symStart_q;

    logic [PHASE_WIDTH-1:0]       offset;
    logic [PHASE_WIDTH-1:0]       lutAddr;
    logic [BW-1:0]                bps;
    logic [BW-1:0]                bitsLeft_d;
    logic [DATA_WIDTH-1:0]        shift_d;
    logic                         symEnd;
    logic                         lastSample;
    logic                         load;

    // Symbol phase offset from the top bit(s) of the shift register, and the
    // handshake window which opens in IDLE or on the final sample of a word.
    always_comb begin
        offset = '0;
        if (!qpsk_q) begin
            offset = shift_q[DATA_WIDTH-1] ? '0 : OFF_HALF;
        end else begin
            case (shift_q[DATA_WIDTH-1 -: 2])
                2'b00:   offset = OFF_1_8;
                2'b01:   offset = OFF_3_8;
                2'b11:   offset = OFF_5_8;
                default: offset = OFF_7_8;
            endcase
        end
        lutAddr    = phaseCnt_q + offset;
        bps        = qpsk_q ? BW'(2) : BW'(1);
        bitsLeft_d = bitsLeft_q - bps;
        shift_d    = qpsk_q ? {shift_q[DATA_WIDTH-3:0], 2'b00}
                            : {shift_q[DATA_WIDTH-2:0], 1'b0};
        symEnd     = (phaseCnt_q == PHASE_MAX);
        lastSample = (state_q == RUN) && symEnd && (bitsLeft_q == bps);
        s_ready    = en && ((state_q == IDLE) || lastSample);
        load       = s_ready && s_valid;
    end

    // Control FSM, serialiser and output sample register, all frozen when en is low.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            phaseCnt_q  <= '0;
            shift_q     <= '0;
            bitsLeft_q  <= '0;
            qpsk_q      <= 1'b0;
            signalOut_q <= '0;
            outValid_q  <= 1'b0;
            symStart_q  <= 1'b0;
        end else if (en) begin
            if (state_q == RUN) begin
                signalOut_q <= sineLut[lutAddr];
                outValid_q  <= 1'b1;
                symStart_q  <= (phaseCnt_q == '0);
            end else begin
                signalOut_q <= '0;
                outValid_q  <= 1'b0;
                symStart_q  <= 1'b0;
            end

            if (load) begin
                shift_q    <= s_data;
                qpsk_q     <= mode;
                bitsLeft_q <= BW'(DATA_WIDTH);
                phaseCnt_q <= '0;
                state_q    <= RUN;
            end else if (state_q == RUN) begin
                phaseCnt_q <= phaseCnt_q + 1'b1;
                if (symEnd) begin
                    shift_q    <= shift_d;
                    bitsLeft_q <= bitsLeft_d;
                    if (bitsLeft_d == '0) begin
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

    assign signal_out = signalOut_q;
    assign out_valid  = outValid_q;
    assign sym_start  = symStart_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_psk_modulator.sv
// Directed self-checking bench for psk_modulator with default parameters
// (12-bit samples, 8-bit words, 256 samples per symbol).
module tb_psk_modulator;

    logic               clk;
    logic               arst;
    logic               en;
    logic               mode;
    logic [7:0]         s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [11:0] signal_out;
    logic               out_valid;
    logic               sym_start;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic signed [11:0] capture [4096];
    int capN;
    int capSyms;
    int capSymErr;

    psk_modulator #(
        .SINE_WIDTH (12),
        .DATA_WIDTH (8),
        .PHASE_WIDTH(8)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .mode      (mode),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .signal_out(signal_out),
        .out_valid (out_valid),
        .sym_start (sym_start),
        .busy      (busy)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so a stuck design still ends the run
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Offer one word; called at a negedge while the DUT is idle, returns at the
    // negedge after the load edge.
    task automatic applyStimulus(input logic [7:0] d, input logic m);
        s_data  = d;
        mode    = m;
        s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Record every valid sample of the current word until out_valid drops.
    task automatic checkOutput();
        capN      = 0;
        capSyms   = 0;
        capSymErr = 0;
        @(negedge clk);
        for (int c = 0; c < 5000; c++) begin
            if (!out_valid) break;
            if (capN < 4096) capture[capN] = signal_out;
            if (sym_start) capSyms++;
            if (sym_start !== ((capN % 256) == 0)) capSymErr++;
            capN++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; en = 1'b1; mode = 1'b0; s_data = '0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (signal_out !== 12'sd0) begin errors++; $display("[TB] FAIL reset_signal: got %0d, expected 0", signal_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++; if (sym_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_sym_start: got %b, expected 0", sym_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        arst = 1'b0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready: got %b, expected 1", s_ready); end
    endtask

    task automatic test_bpsk_single();
        applyStimulus(8'hA5, 1'b0);
        checkOutput();
        checks++; if (capN !== 2048) begin errors++; $display("[TB] FAIL bpsk_samples: got %0d, expected 2048", capN); end
        checks++; if (capSyms !== 8) begin errors++; $display("[TB] FAIL bpsk_syms: got %0d, expected 8", capSyms); end
        checks++; if (capSymErr !== 0) begin errors++; $display("[TB] FAIL bpsk_sym_pos: got %0d misplaced, expected 0", capSymErr); end
        checks++; if (capture[0] !== 12'sd0) begin errors++; $display("[TB] FAIL bpsk_s0: got %0d, expected 0", capture[0]); end
        checks++; if (capture[64] !== 12'sd2047) begin errors++; $display("[TB] FAIL bpsk_s64: got %0d, expected 2047", capture[64]); end
        checks++; if (capture[320] !== -12'sd2047) begin errors++; $display("[TB] FAIL bpsk_s320: got %0d, expected -2047", capture[320]); end
        checks++; if (capture[576] !== 12'sd2047) begin errors++; $display("[TB] FAIL bpsk_s576: got %0d, expected 2047", capture[576]); end
        checks++; if (capture[1856] !== 12'sd2047) begin errors++; $display("[TB] FAIL bpsk_s1856: got %0d, expected 2047", capture[1856]); end
        checks++; if (out_valid !== 1'b0 || signal_out !== 12'sd0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL bpsk_after: got valid=%b sig=%0d busy=%b, expected 0/0/0", out_valid, signal_out, busy);
        end
    endtask

    task automatic test_qpsk();
        applyStimulus(8'b00_01_11_10, 1'b1);
        checkOutput();
        checks++; if (capN !== 1024) begin errors++; $display("[TB] FAIL qpsk_samples: got %0d, expected 1024", capN); end
        checks++; if (capSyms !== 4) begin errors++; $display("[TB] FAIL qpsk_syms: got %0d, expected 4", capSyms); end
        checks++; if (capture[0] !== 12'sd1447) begin errors++; $display("[TB] FAIL qpsk_sym0: got %0d, expected 1447", capture[0]); end
        checks++; if (capture[256] !== 12'sd1447) begin errors++; $display("[TB] FAIL qpsk_sym1: got %0d, expected 1447", capture[256]); end
        checks++; if (capture[512] !== -12'sd1447) begin errors++; $display("[TB] FAIL qpsk_sym2: got %0d, expected -1447", capture[512]); end
        checks++; if (capture[768] !== -12'sd1447) begin errors++; $display("[TB] FAIL qpsk_sym3: got %0d, expected -1447", capture[768]); end
        checks++; if (capture[32] !== 12'sd2047) begin errors++; $display("[TB] FAIL qpsk_s32: got %0d, expected 2047", capture[32]); end
    endtask

    task automatic test_back_to_back();
        int readyCnt = 0;
        int firstReady = -1;
        int secondReady = -1;
        int gaps = 0;
        s_data = 8'hFF; mode = 1'b0; s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_data = 8'h00;
        // At step c the DUT is computing sample c and shows sample c-1
        for (int c = 0; c <= 4097; c++) begin
            if (c <= 4095 && s_ready) begin
                readyCnt++;
                if (readyCnt == 1) firstReady = c;
                else secondReady = c;
            end
            if (readyCnt >= 1 && c > firstReady) s_valid = 1'b0;
            if (c >= 1 && c <= 4096 && out_valid !== 1'b1) gaps++;
            if (c == 65) begin
                checks++; if (signal_out !== 12'sd2047) begin errors++; $display("[TB] FAIL b2b_s64: got %0d, expected 2047", signal_out); end
            end
            if (c == 2049) begin
                checks++; if (signal_out !== 12'sd0) begin errors++; $display("[TB] FAIL b2b_s2048: got %0d, expected 0", signal_out); end
                checks++; if (sym_start !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sym2048: got %b, expected 1", sym_start); end
            end
            if (c == 2113) begin
                checks++; if (signal_out !== -12'sd2047) begin errors++; $display("[TB] FAIL b2b_s2112: got %0d, expected -2047", signal_out); end
            end
            if (c == 4097) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got %b, expected 0", out_valid); end
            end
            if (c < 4097) @(negedge clk);
        end
        s_valid = 1'b0;
        checks++; if (firstReady !== 2047) begin errors++; $display("[TB] FAIL b2b_ready1: got %0d, expected 2047", firstReady); end
        checks++; if (secondReady !== 4095) begin errors++; $display("[TB] FAIL b2b_ready2: got %0d, expected 4095", secondReady); end
        checks++; if (gaps !== 0) begin errors++; $display("[TB] FAIL b2b_gaps: got %0d, expected 0", gaps); end
    endtask

    task automatic test_enable_hold();
        int total;
        applyStimulus(8'hA5, 1'b0);
        for (int k = 0; k <= 100; k++) @(negedge clk);
        checks++; if (signal_out !== 12'sd1299) begin errors++; $display("[TB] FAIL en_s100: got %0d, expected 1299", signal_out); end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || signal_out !== 12'sd1299 || s_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("[TB] FAIL en_hold%0d: got valid=%b sig=%0d ready=%b busy=%b, expected 1/1299/0/1", k, out_valid, signal_out, s_ready, busy);
            end
        end
        en = 1'b1;
        @(negedge clk);
        checks++; if (signal_out !== 12'sd1259) begin errors++; $display("[TB] FAIL en_s101: got %0d, expected 1259", signal_out); end
        total = 102;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!out_valid) break;
            total++;
        end
        checks++; if (total !== 2048) begin errors++; $display("[TB] FAIL en_total: got %0d, expected 2048", total); end
    endtask

    task automatic test_async_reset();
        applyStimulus(8'hA5, 1'b0);
        for (int k = 0; k <= 818; k++) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre: got %b, expected 1", out_valid); end
        #2 arst = 1'b1;
        #1;
        checks++; if (signal_out !== 12'sd0 || out_valid !== 1'b0 || sym_start !== 1'b0) begin
            errors++; $display("[TB] FAIL ar_async: got sig=%0d valid=%b sym=%b, expected 0/0/0", signal_out, out_valid, sym_start);
        end
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL ar_idle: got busy=%b ready=%b, expected 0/1", busy, s_ready);
        end
        applyStimulus(8'h80, 1'b0);
        checkOutput();
        checks++; if (capN !== 2048) begin errors++; $display("[TB] FAIL ar_samples: got %0d, expected 2048", capN); end
        checks++; if (capture[64] !== 12'sd2047) begin errors++; $display("[TB] FAIL ar_s64: got %0d, expected 2047", capture[64]); end
        checks++; if (capture[320] !== -12'sd2047) begin errors++; $display("[TB] FAIL ar_s320: got %0d, expected -2047", capture[320]); end
        checks++; if (capSymErr !== 0) begin errors++; $display("[TB] FAIL ar_sym_pos: got %0d misplaced, expected 0", capSymErr); end
    endtask

    task automatic test_mode_change();
        applyStimulus(8'hA5, 1'b0);
        mode = 1'b1;
        checkOutput();
        checks++; if (capSyms !== 8) begin errors++; $display("[TB] FAIL mc_bpsk_syms: got %0d, expected 8", capSyms); end
        checks++; if (capN !== 2048) begin errors++; $display("[TB] FAIL mc_bpsk_samples: got %0d, expected 2048", capN); end
        applyStimulus(8'h1B, 1'b1);
        checkOutput();
        checks++; if (capSyms !== 4) begin errors++; $display("[TB] FAIL mc_qpsk_syms: got %0d, expected 4", capSyms); end
        checks++; if (capN !== 1024) begin errors++; $display("[TB] FAIL mc_qpsk_samples: got %0d, expected 1024", capN); end
        checks++; if (capture[0] !== 12'sd1447) begin errors++; $display("[TB] FAIL mc_qpsk_s0: got %0d, expected 1447", capture[0]); end
        checks++; if (capture[512] !== -12'sd1447) begin errors++; $display("[TB] FAIL mc_qpsk_s512: got %0d, expected -1447", capture[512]); end
        checks++; if (capture[768] !== -12'sd1447) begin errors++; $display("[TB] FAIL mc_qpsk_s768: got %0d, expected -1447", capture[768]); end
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] psk_modulator bench start");
        test_reset();
        test_bpsk_single();
        test_qpsk();
        test_back_to_back();
        test_enable_hold();
        test_async_reset();
        test_mode_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psk_modulator.md
Name: psk_modulator

Overview:
Parametrised successor to the single-mode BPSK modulator. It is a streaming PSK modulator that accepts data words over a valid/ready handshake and serialises them MSB-first into BPSK (1 bit/symbol) or Gray-coded QPSK (2 bits/symbol) symbols. Each symbol is one full carrier period read from an internal signed sine LUT, with the symbol's phase offset added to the LUT address. It sits between the framer/data source and the DAC interface of the transmitter.

Parameters:
SINE_WIDTH, 12, signed output sample width; LUT amplitude A = 2^(SINE_WIDTH-1)-1.
DATA_WIDTH, 8, input word width; must be even (QPSK consumes 2 bits per symbol).
PHASE_WIDTH, 8, LUT address width; N = 2^PHASE_WIDTH samples per carrier period, which is also samples per symbol; N must be ≥ 8.

Ports:
clk  in  1  clock.
arst  in  1  asynchronous reset, active-high.
en  in  1  clock enable; when low, all state freezes.
mode  in  1  0 = BPSK, 1 = QPSK; sampled only at word load.
s_data  in  DATA_WIDTH  input word, transmitted MSB first.
s_valid  in  1  s_data valid.
s_ready  out  1  word accepted on a cycle where s_valid && s_ready && en.
signal_out  out  SINE_WIDTH  signed two's-complement carrier sample.
out_valid  out  1  signal_out holds a live modulated sample.
sym_start  out  1  high with the first sample of each symbol.
busy  out  1  high in RUN state.

Behaviour:
- Reset (async): state = IDLE; phase_cnt, shift register, bits_left = 0; signal_out = 0; out_valid = 0; sym_start = 0. Takes effect immediately mid-symbol; any partially sent word is discarded.
- LUT: LUT[a] = round(A*sin(2πa/N)), a in 0..N-1. Read is combinational; the result is registered into signal_out.
- States:
  - IDLE: s_ready = en.
  - RUN: s_ready = en && (last sample of last symbol of the current word).
- Word load on handshake (from IDLE, or on the last RUN sample):
  - shift register = s_data; mode is latched; bits_left = DATA_WIDTH; phase_cnt = 0; state = RUN.
- Phase offset, in LUT steps (addresses are mod N):
  - BPSK: bit 1 → 0; bit 0 → N/2.
  - QPSK: dibit 00 → N/8; 01 → 3N/8; 11 → 5N/8; 10 → 7N/8.
- RUN, each en cycle:
  - LUT address = phase_cnt + offset(top bits of the shift register).
  - phase_cnt increments, wrapping at N.
  - When phase_cnt = N-1: shift left by bps (1 or 2) and set bits_left -= bps.
  - If bits_left reaches 0 and a handshake occurs in the same cycle, load the new word (no gap).
  - If bits_left reaches 0 with no handshake, go to IDLE.
- Output register (updates only when en = 1):
  - signal_out = LUT[address].
  - out_valid = (state == RUN).
  - sym_start = (state == RUN && phase_cnt == 0).
  - In IDLE: signal_out = 0, out_valid = 0.
- Latency: the first valid sample is registered on the clock edge after the load edge (2 edges after the handshake cycle begins). Back-to-back words produce a continuous out_valid stream.
- en = 0: phase_cnt, shift register, state and all outputs hold; s_ready = 0; no handshake occurs.
- A mode change while in RUN has no effect until the next word load.
- Symbols per word: DATA_WIDTH/bps. Samples per word: N*DATA_WIDTH/bps.

Test Plan:
- Defaults, BPSK, s_data = 8'hA5, single word → 2048 out_valid samples, 8 sym_start pulses. Symbol 0 (bit 1): sample 64 = +2047. Symbol 1 (bit 0): sample 64 = -2047. Afterwards out_valid = 0, signal_out = 0, busy = 0.
- QPSK, s_data = 8'b00_01_11_10 → 4 symbols of 256 samples. First samples are LUT[32] = +1447, LUT[96] = +1447, LUT[160] = -1447, LUT[224] = -1447.
- s_valid held high with words 8'hFF then 8'h00, BPSK → s_ready pulses exactly at sample 2047. out_valid has no gap. Sample 2048 = LUT[128] = 0, sample 2112 = -2047.
- en low for 10 cycles at sample 100 of a symbol → signal_out and out_valid hold. The stream resumes at sample 101. Total samples are unchanged.
- arst pulse mid-symbol (sample 50 of symbol 3) → signal_out, out_valid and sym_start go to 0 asynchronously. State is IDLE with s_ready = 1 after release. The next word starts at phase 0.
- mode toggled 0→1 during a BPSK word → remaining symbols stay BPSK. The next loaded word is QPSK (4 sym_start pulses).
